ysyx_24080014_lsu_axi: RTL

Parametrised load/store unit that sits between the core's execute/memory stage and the data-side AXI4-lite bus. It accepts one load or store request at a time through a valid/ready handshake and runs a proper AXI4-lite master state machine with independent AW/W completion and B/R response tracking. It handles byte-lane alignment, write strobes, zero/sign extension and misalignment detection, and returns the bus response code. It is a generalisation of the current memory stage: data width is parametric, handshakes are true two-way, and errors are reported instead of dropped.

---
 rtl/ysyx_24080014_lsu_axi.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ysyx_24080014_lsu_axi.sv
// ysyx_24080014_lsu_axi: load/store unit bridging one request at a time onto an AXI4-lite master
// Ports: clk/rst (async active-high); req_* request handshake with size/sign/store data;
// rsp_* response handshake returning extended load data and an error flag;
// aw/w/b/ar/r AXI4-lite master channels (valids and readies are decodes of registered state).
module ysyx_24080014_lsu_axi #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W = $clog2(STRB_W);
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, RESP} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, sh;
    logic [STRB_W-1:0] wstrb_q;
    logic [OFF_W-1:0] off_q, off;
    logic [1:0] size_q;
    logic signed_q, err_q, aw_done_q, w_done_q, accept, bad;
    logic [7:0] bmask;
    logic [15:0] strb_w;
    logic [63:0] sh64, ext64;
    always_comb begin
        accept = state_q == IDLE && req_valid;
        off = req_addr[OFF_W-1:0];
        // low address bits under the size mask must be zero; dword only exists on a 64-bit bus
        bad = (DATA_W == 32 && req_size == 2'd3) || (req_addr[2:0] & ((3'd1 << req_size) - 3'd1)) != 3'd0;
        // size 3 wraps 1<<8 to 0 in 8 bits, so the subtraction yields all eight lanes
        bmask = (8'd1 << (4'd1 << req_size)) - 8'd1;
        strb_w = {8'd0, bmask} << off;
        sh = rdata >> {off_q, 3'b000};
        // extend in a fixed 64-bit frame so one expression serves both bus widths
        sh64 = 64'(sh);
        ext64 = size_q == 2'd0 ? {{56{signed_q & sh64[7]}}, sh64[7:0]} :
                size_q == 2'd1 ? {{48{signed_q & sh64[15]}}, sh64[15:0]} :
                size_q == 2'd2 ? {{32{signed_q & sh64[31]}}, sh64[31:0]} : sh64;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid) state_d = bad ? RESP : (req_we ? WR : RD_A);
            RD_A: if (arready) state_d = RD_D;
            RD_D: if (rvalid) state_d = RESP;
            WR:   if ((aw_done_q || awready) && (w_done_q || wready)) state_d = WR_B;
            WR_B: if (bvalid) state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        req_ready = state_q == IDLE;
        arvalid = state_q == RD_A;
        rready = state_q == RD_D;
        awvalid = state_q == WR && !aw_done_q;
        wvalid = state_q == WR && !w_done_q;
        bready = state_q == WR_B;
        rsp_valid = state_q == RESP;
        awaddr = addr_q;
        araddr = addr_q;
        wdata = wdata_q;
        wstrb = wstrb_q;
        rsp_rdata = rdata_q;
        rsp_err = err_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            off_q <= '0;
            size_q <= '0;
            signed_q <= 1'b0;
            err_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                wdata_q <= req_wdata << {off, 3'b000};
                wstrb_q <= strb_w[STRB_W-1:0];
                off_q <= off;
                size_q <= req_size;
                signed_q <= req_signed;
                aw_done_q <= 1'b0;
                w_done_q <= 1'b0;
                if (bad) begin
                    rdata_q <= '0;
                    err_q <= 1'b1;
                end
            end
            if (awvalid && awready) aw_done_q <= 1'b1;
            if (wvalid && wready) w_done_q <= 1'b1;
            if (rready && rvalid) begin
                rdata_q <= rresp == 2'b00 ? ext64[DATA_W-1:0] : '0;
                err_q <= rresp != 2'b00;
            end
            if (bready && bvalid) begin
                rdata_q <= '0;
                err_q <= bresp != 2'b00;
            end
        end
    end
endmodule
